// File: rtl/seq_mult8_ctrl_if.sv
// seq_mult8_ctrl_if: operand/product handshake bundle for the sequential multiplier
interface seq_mult8_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;
    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, product, busy);
    modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, product, busy);
endinterface

// File: rtl/seq_mult8_ctrl.sv
// seq_mult8_ctrl: 8x8 shift-and-add multiplier reusing one 8-bit ripple adder for 8 cycles
module eight_bit_full_adder (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [8:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign sum[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    assign cout = c[8];
endmodule

module seq_mult8_ctrl (
    input logic             clk,
    input logic             rst_n,
    seq_mult8_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q, state_d;
    logic [7:0]  m_q, m_d, a_q, a_d, q_q, q_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] product_q, product_d;
    logic [7:0]  sum;
    logic        cout;
    logic [15:0] shifted;
    eight_bit_full_adder u_add (
        .x    (a_q),
        .y    (q_q[0] ? m_q : 8'h00),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );
    // carry-out re-enters as the new MSB of the shifted partial product
    assign shifted = {cout, sum, q_q[7:1]};
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                m_d     = bus.a;
                q_d     = bus.b;
                a_d     = 8'h00;
                cnt_d   = 3'd0;
                state_d = RUN;
            end
            RUN: begin
                {a_d, q_d} = shifted;
                cnt_d      = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d   = DONE;
                    product_d = shifted;
                end
            end
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_q       <= 8'h00;
            a_q       <= 8'h00;
            q_q       <= 8'h00;
            cnt_q     <= 3'd0;
            product_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN);
    assign bus.product   = product_q;
endmodule

// File: tb/tb_seq_mult8_ctrl.sv
// tb_seq_mult8_ctrl: random and directed operand pairs checked against plain a*b
module tb_seq_mult8_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    seq_mult8_ctrl_if bus ();
    seq_mult8_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [7:0] x, input logic [7:0] y, input int hold, input bit spurious);
        logic [15:0] exp;
        exp = 16'(x) * 16'(y);
        @(negedge clk);
        check("idle_ready", bus.in_ready, 1);
        check("idle_ovalid", bus.out_valid, 0);
        bus.in_valid = 1'b1;
        bus.a = x;
        bus.b = y;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = spurious;
        if (spurious) begin
            bus.a = 8'hFF;
            bus.b = 8'hFF;
            bus.out_ready = 1'b1;
        end
        for (int k = 0; k < 8; k++) begin
            check("run_busy", bus.busy, 1);
            check("run_ready", bus.in_ready, 0);
            check("run_ovalid", bus.out_valid, 0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("done_ovalid", bus.out_valid, 1);
        check("done_ready", bus.in_ready, 0);
        check("done_busy", bus.busy, 0);
        check("product", bus.product, exp);
        bus.out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_ovalid", bus.out_valid, 1);
            check("hold_product", bus.product, exp);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("drain_ready", bus.in_ready, 1);
        check("drain_ovalid", bus.out_valid, 0);
        check("drain_product", bus.product, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=0 expected=1");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.a = 8'h00;
        bus.b = 8'h00;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", bus.in_ready, 1);
        check("rst_ovalid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_product", bus.product, 0);
        rst_n = 1'b1;
        do_op(8'h0D, 8'h0B, 0, 1'b0);
        do_op(8'hFF, 8'hFF, 0, 1'b0);
        do_op(8'h00, 8'h5A, 0, 1'b0);
        do_op(8'hA5, 8'h00, 0, 1'b0);
        do_op(8'h80, 8'h02, 5, 1'b0);
        do_op(8'h12, 8'h34, 0, 1'b1);
        // abort a multiply after four RUN cycles
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = 8'hC3;
        bus.b = 8'h5A;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", bus.busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mrst_ovalid", bus.out_valid, 0);
        check("mrst_ready", bus.in_ready, 1);
        check("mrst_busy", bus.busy, 0);
        check("mrst_product", bus.product, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("mrst_quiet", bus.out_valid, 0);
        end
        do_op(8'h03, 8'h07, 0, 1'b0);
        for (int n = 0; n < 25; n++)
            do_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
